wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of buffered write-back entries (power of two, >=2).
REQ-002 The block SHALL have these ports:
- CLK  in  1  sole clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- InValid  in  1  write request present.
- InReady  out  1  block can accept a request this cycle.
- InReg  in  5  destination register number.
- InData  in  32  destination write data.
- WbStall  in  1  register-file write port unavailable this cycle.
- RegWre  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- WriteData  out  32  register-file write data.
- ReadReg1  in  5  decode-stage read address, port 1.
- ReadReg2  in  5  decode-stage read address, port 2.
- Hit1  out  1  ReadReg1 has a pending write in the queue.
- Hit2  out  1  ReadReg2 has a pending write in the queue.
- FwdData1  out  32  youngest pending data for ReadReg1.
- FwdData2  out  32  youngest pending data for ReadReg2.
- Count  out  clog2(DEPTH)+1  number of valid entries.

Function
REQ-003 The block SHALL be an in-order FIFO of {reg, data} entries feeding the register-file write port.
REQ-004 A push SHALL occur on a posedge when InValid=1 and InReady=1; InReady SHALL equal (Count<DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-005 A request with InReg=0 SHALL be accepted and discarded: no entry, no Count change.
REQ-006 RegWre SHALL equal (Count!=0 && WbStall==0), combinational; WriteReg/WriteData SHALL show the head entry whenever Count!=0 and SHALL be 0 when empty.
REQ-007 A pop SHALL occur on every posedge where RegWre=1.
REQ-008 Latency: an entry pushed into an empty queue at posedge N SHALL drive RegWre in cycle N..N+1 and pop at posedge N+1 if WbStall=0.
REQ-009 Simultaneous push and pop SHALL leave Count unchanged; with Count=DEPTH no push SHALL occur even if a pop occurs.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH.
REQ-011 Hit1 SHALL be 1 iff ReadReg1!=0 and some valid entry, including the head being popped, has reg==ReadReg1; the same rule SHALL apply to Hit2/ReadReg2.
REQ-012 FwdDataN SHALL be the data of the youngest matching entry (closest to the tail); 0 when HitN=0.
REQ-013 A request being pushed in the current cycle SHALL NOT be forwarded until the cycle after its push.
REQ-014 Forwarding and RegWre logic SHALL be combinational from registered state and current inputs; no other output latency.

Reset
REQ-015 When Reset=0 at a posedge, pointers, Count, and all entry valid bits SHALL clear; entry data need not clear.
REQ-016 While Reset=0, InReady, RegWre, Hit1 and Hit2 SHALL be forced to 0.
REQ-017 Reset asserted mid-operation SHALL drop all pending writes; no partial write SHALL be issued afterwards.

Structure
REQ-018 Shared package mips_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, and the wb_entry_t {valid, reg, data} typedef.
REQ-019 One sub-module, wb_fwd_match (address-in, entry array plus tail pointer in, hit/data out, youngest-wins priority), SHALL be instantiated twice.

Verification
REQ-020 Reset, then push (r5, 0x11) with WbStall=0 -> next cycle RegWre=1, WriteReg=5, WriteData=0x11; Count returns 0 one posedge later.
REQ-021 WbStall=1; push r3=0xA, r3=0xB, r7=0xC -> Count=3, ReadReg1=3 gives Hit1=1, FwdData1=0xB; ReadReg2=7 gives FwdData2=0xC.
REQ-022 WbStall=1; push DEPTH entries -> InReady=0; additional InValid is ignored; release stall -> entries drain in order, one per cycle.
REQ-023 Push InReg=0, data 0xFFFF -> Count stays 0, RegWre stays 0, Hit for ReadReg=0 stays 0.
REQ-024 Queue holds 3 entries; drive Reset=0 for one posedge -> Count=0 and RegWre=0 next cycle, with no stale write after release.
REQ-025 Full queue, WbStall=0, InValid=1 -> pop without push; the push completes on the following cycle, and the wrap-around order is preserved across 10 entries.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths and write-back entry type
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // 'reg' is a reserved word, so the destination register field is regnum
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] regnum;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-wins address match over the write-back entries
module wb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_ADDR_W-1:0]       i_addr,
  input  wb_entry_t [DEPTH-1:0]       i_entries,
  input  logic [$clog2(DEPTH)-1:0]    i_tail,
  output logic                        o_hit,
  output logic [DATA_W-1:0]           o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] w_idx;

  // Walk slots from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
  // Register 0 is never a real destination, so it never hits.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_tail - AW'(k);
      if (i_entries[w_idx].valid && (i_entries[w_idx].regnum == i_addr) && (i_addr != '0)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back queue with decode-stage forwarding
module wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [REG_ADDR_W-1:0]   InReg,
  input  logic [DATA_W-1:0]       InData,
  input  logic                    WbStall,
  output logic                    RegWre,
  output logic [REG_ADDR_W-1:0]   WriteReg,
  output logic [DATA_W-1:0]       WriteData,
  input  logic [REG_ADDR_W-1:0]   ReadReg1,
  input  logic [REG_ADDR_W-1:0]   ReadReg2,
  output logic                    Hit1,
  output logic                    Hit2,
  output logic [DATA_W-1:0]       FwdData1,
  output logic [DATA_W-1:0]       FwdData2,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_nonempty;
  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_pop;
  wb_entry_t             w_head;
  logic                  w_hit1;
  logic                  w_hit2;
  logic [DATA_W-1:0]     w_fwd1;
  logic [DATA_W-1:0]     w_fwd2;

  assign w_nonempty = (r_count != '0);
  // Ready looks only at stored occupancy, never at a same-cycle pop
  assign w_in_ready = Reset & (r_count < CW'(DEPTH));
  // Writes to register 0 are acknowledged but never stored
  assign w_push     = InValid & w_in_ready & (InReg != '0);
  assign w_pop      = Reset & w_nonempty & ~WbStall;
  assign w_head     = r_entries[r_rptr];

  assign InReady    = w_in_ready;
  assign RegWre     = w_pop;
  assign WriteReg   = w_nonempty ? w_head.regnum : '0;
  assign WriteData  = w_nonempty ? w_head.data   : '0;
  assign Count      = r_count;

  assign Hit1       = Reset & w_hit1;
  assign Hit2       = Reset & w_hit2;
  assign FwdData1   = (Reset & w_hit1) ? w_fwd1 : '0;
  assign FwdData2   = (Reset & w_hit2) ? w_fwd2 : '0;

  wb_fwd_match #(.DEPTH(DEPTH)) u_match1 (
    .i_addr    (ReadReg1),
    .i_entries (r_entries),
    .i_tail    (r_wptr),
    .o_hit     (w_hit1),
    .o_data    (w_fwd1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_match2 (
    .i_addr    (ReadReg2),
    .i_entries (r_entries),
    .i_tail    (r_wptr),
    .o_hit     (w_hit2),
    .o_data    (w_fwd2)
  );

  // Queue state: pointers wrap naturally at DEPTH; reset drops every pending write
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_entries[r_rptr].valid <= 1'b0;
        r_rptr                  <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_entries[r_wptr] <= '{valid: 1'b1, regnum: InReg, data: InData};
        r_wptr            <= r_wptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue against a queue model
module tb_wb_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic                  CLK = 1'b0;
  logic                  Reset;
  logic                  InValid;
  logic                  InReady;
  logic [4:0]            InReg;
  logic [31:0]           InData;
  logic                  WbStall;
  logic                  RegWre;
  logic [4:0]            WriteReg;
  logic [31:0]           WriteData;
  logic [4:0]            ReadReg1;
  logic [4:0]            ReadReg2;
  logic                  Hit1;
  logic                  Hit2;
  logic [31:0]           FwdData1;
  logic [31:0]           FwdData2;
  logic [$clog2(DEPTH):0] Count;

  ent_t mdl[$];
  ent_t exp_q[$];
  ent_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic acc;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InData(InData), .WbStall(WbStall), .RegWre(RegWre),
    .WriteReg(WriteReg), .WriteData(WriteData), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .Hit1(Hit1), .Hit2(Hit2), .FwdData1(FwdData1),
    .FwdData2(FwdData2), .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] a, input logic rst,
                                    output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rst && a != 5'd0) begin
      foreach (mdl[i]) begin
        if (mdl[i].r == a) begin
          hit = 1'b1;
          d   = mdl[i].d;
        end
      end
    end
  endfunction

  task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic st, input logic [4:0] a1, input logic [4:0] a2,
                       input logic rst, output logic accepted);
    logic        exp_rdy;
    logic        exp_wre;
    logic        h;
    logic [31:0] f;
    ent_t        e;
    @(negedge CLK);
    InValid = v; InReg = r; InData = d; WbStall = st;
    ReadReg1 = a1; ReadReg2 = a2; Reset = rst;
    #1;
    exp_rdy = rst && (mdl.size() < DEPTH);
    exp_wre = rst && (mdl.size() != 0) && !st;
    chk("count", 32'(Count), 32'(mdl.size()));
    chk("in_ready", 32'(InReady), 32'(exp_rdy));
    chk("regwre", 32'(RegWre), 32'(exp_wre));
    if (mdl.size() == 0) begin
      chk("write_reg_empty", 32'(WriteReg), 32'd0);
      chk("write_data_empty", WriteData, 32'd0);
    end
    model_fwd(a1, rst, h, f);
    chk("hit1", 32'(Hit1), 32'(h));
    chk("fwd1", FwdData1, f);
    model_fwd(a2, rst, h, f);
    chk("hit2", 32'(Hit2), 32'(h));
    chk("fwd2", FwdData2, f);
    @(posedge CLK);
    accepted = exp_rdy && v;
    if (!rst) begin
      mdl.delete();
      exp_q.delete();
    end else begin
      if (exp_wre) void'(mdl.pop_front());
      if (accepted && r != 5'd0) begin
        e.r = r;
        e.d = d;
        mdl.push_back(e);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic st);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, st, 5'd0, 5'd0, 1'b1, a);
  endtask

  // Monitor: every register-file write must match the oldest outstanding request
  always @(negedge CLK) begin
    #2;
    if (RegWre === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: write r%0d=%h with nothing pending at %0t",
                 WriteReg, WriteData, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_reg", 32'(WriteReg), 32'(mon_e.r));
        chk("wb_data", WriteData, mon_e.d);
      end
    end
  end

  initial begin
    Reset = 1'b0; InValid = 1'b0; InReg = '0; InData = '0; WbStall = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0;
    repeat (2) @(posedge CLK);

    // single write through an empty queue
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd0, 1'b1, acc);
    idle(2, 1'b0);

    // stalled pushes with repeated destination: youngest data forwards
    cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 5'd7, 1'b1, acc);
    cycle(1'b1, 5'd3, 32'hB, 1'b1, 5'd3, 5'd7, 1'b1, acc);
    cycle(1'b1, 5'd7, 32'hC, 1'b1, 5'd3, 5'd7, 1'b1, acc);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 1'b1, acc);
    idle(4, 1'b0);

    // fill under stall, overflow attempts ignored, then in-order drain
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'(i), 5'(i + 1), 1'b1, acc);
    idle(DEPTH + 1, 1'b0);

    // register 0 is swallowed
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 1'b1, acc);
    idle(2, 1'b0);

    // reset with pending writes drops them all
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(i + 9), 32'h200 + i, 1'b1, 5'd9, 5'd10, 1'b1, acc);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd10, 1'b0, acc);
    idle(3, 1'b0);

    // full queue with stall released: pop first, push completes next cycle; 10 entries wrap
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 5'(i + 20), 32'h300 + i, 1'b1, 5'd20, 5'd21, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++)
        cycle(1'b1, 5'(i + 1), 32'h400 + i, 1'b0, 5'(i + 1), 5'(i), 1'b1, acc);
      chk("wrap_push_accepted", 32'(acc), 32'd1);
    end
    idle(DEPTH + 2, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 59) != 0), acc);
    end
    idle(DEPTH + 2, 1'b0);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
